fp16_align: RTL and testbench

FP16_ALIGN -- requirements
Module: fp16_align

---
 rtl/fp16_pkg.sv | 24 ++
 rtl/fp16_unpack.sv | 24 ++
 rtl/fp16_align.sv | 128 ++++++++++++
 tb/tb_fp16_align.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// FP16 operand alignment: shared widths, constants, FSM states and the
// unpacked-operand record used by the unpack stage and the aligner top.
package fp16_pkg;
  localparam int FP_W        = 16;
  localparam int EXP_W       = 5;
  localparam int FRAC_W      = 10;
  localparam int MANT_W      = 12;   // {guard 0, hidden, frac}
  localparam int CNT_W       = 4;
  localparam int EXP_SPECIAL = 31;   // Inf/NaN exponent
  localparam int MAX_SHIFT   = 12;   // a 12-bit mantissa is fully gone after 12 shifts

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;      // effective exponent (denormals read as 1)
    logic [MANT_W-1:0] mant;
    logic              special;  // raw exponent is all ones
  } fp16_unp_t;
endpackage

// File: rtl/fp16_unpack.sv
// Splits one FP16 word into sign, effective exponent, mantissa with hidden
// bit, and an Inf/NaN flag.
//   i_fp : raw FP16 operand
//   o_op : unpacked fields
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic [FP_W-1:0] i_fp,
  output fp16_unp_t       o_op
);
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_hidden;

  assign w_exp    = i_fp[FP_W-2 -: EXP_W];
  assign w_frac   = i_fp[FRAC_W-1:0];
  assign w_hidden = |w_exp;

  assign o_op.sign    = i_fp[FP_W-1];
  // denormals share the scale of exponent 1
  assign o_op.exp     = w_hidden ? w_exp : EXP_W'(1);
  assign o_op.mant    = {1'b0, w_hidden, w_frac};
  assign o_op.special = (w_exp == EXP_W'(EXP_SPECIAL));
endmodule

// File: rtl/fp16_align.sv
// FP16 adder front end: orders two operands by effective exponent and
// right-shifts the smaller mantissa one bit per cycle until both share the
// larger exponent, collecting a sticky bit from the bits shifted out.
//   clk, rst_n             : clock, async active-low reset
//   in_valid / in_ready    : operand handshake (a_in, b_in)
//   out_valid / out_ready  : result handshake
//   exponent_out           : common (larger) effective exponent
//   mant_a_out, mant_b_out : larger / aligned smaller mantissa
//   sign_a_out, sign_b_out : signs after the swap
//   swap_out               : operands were exchanged
//   sticky_out             : OR of bits shifted out of mant_b
//   special_out            : an operand was Inf/NaN
module fp16_align
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   a_in,
  input  logic [FP_W-1:0]   b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXP_W-1:0]  exponent_out,
  output logic [MANT_W-1:0] mant_a_out,
  output logic [MANT_W-1:0] mant_b_out,
  output logic              sign_a_out,
  output logic              sign_b_out,
  output logic              swap_out,
  output logic              sticky_out,
  output logic              special_out
);
  fp16_unp_t         w_ua, w_ub, w_big, w_small;
  logic              w_swap, w_special, w_capture;
  logic [EXP_W-1:0]  w_diff;
  logic [CNT_W-1:0]  w_d;
  state_t            r_state, w_state_nxt;

  logic [CNT_W-1:0]  r_cnt;
  logic [EXP_W-1:0]  r_exp;
  logic [MANT_W-1:0] r_mant_a, r_mant_b;
  logic              r_sign_a, r_sign_b, r_swap, r_sticky, r_special, r_out_valid;

  fp16_unpack u_unp_a (.i_fp(a_in), .o_op(w_ua));
  fp16_unpack u_unp_b (.i_fp(b_in), .o_op(w_ub));

  // equal exponents keep the original order
  assign w_swap    = (w_ub.exp > w_ua.exp);
  assign w_big     = w_swap ? w_ub : w_ua;
  assign w_small   = w_swap ? w_ua : w_ub;
  assign w_diff    = w_big.exp - w_small.exp;
  assign w_special = w_ua.special | w_ub.special;

  always_comb begin
    w_d = '0;
    if (!w_special) begin
      if (w_diff > EXP_W'(MAX_SHIFT)) w_d = CNT_W'(MAX_SHIFT);
      else                            w_d = w_diff[CNT_W-1:0];
    end
  end

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_capture = in_valid && in_ready;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_capture) w_state_nxt = (w_d == '0) ? DONE : SHIFT;
      // r_cnt == 1 means this cycle's shift is the last one
      SHIFT: if (r_cnt <= CNT_W'(1)) w_state_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (w_capture) w_state_nxt = (w_d == '0) ? DONE : SHIFT;
          else           w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_exp     <= '0;
      r_mant_a  <= '0;
      r_mant_b  <= '0;
      r_sign_a  <= 1'b0;
      r_sign_b  <= 1'b0;
      r_swap    <= 1'b0;
      r_sticky  <= 1'b0;
      r_special <= 1'b0;
    end else if (w_capture) begin
      r_cnt     <= w_d;
      r_exp     <= w_big.exp;
      r_mant_a  <= w_big.mant;
      r_mant_b  <= w_small.mant;
      r_sign_a  <= w_big.sign;
      r_sign_b  <= w_small.sign;
      r_swap    <= w_swap;
      r_sticky  <= 1'b0;
      r_special <= w_special;
    end else if ((r_state == SHIFT) && (r_cnt != '0)) begin
      r_mant_b  <= r_mant_b >> 1;
      r_sticky  <= r_sticky | r_mant_b[0];
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  assign out_valid    = r_out_valid;
  assign exponent_out = r_exp;
  assign mant_a_out   = r_mant_a;
  assign mant_b_out   = r_mant_b;
  assign sign_a_out   = r_sign_a;
  assign sign_b_out   = r_sign_b;
  assign swap_out     = r_swap;
  assign sticky_out   = r_sticky;
  assign special_out  = r_special;
endmodule

// File: tb/tb_fp16_align.sv
module tb_fp16_align;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_in = '0, b_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [4:0]  exponent_out;
  logic [11:0] mant_a_out, mant_b_out;
  logic        sign_a_out, sign_b_out, swap_out, sticky_out, special_out;

  int errors = 0;
  int checks = 0;

  // expected result of the transaction in flight
  int e_exp, e_ma, e_mb, e_sa, e_sb, e_sw, e_st, e_sp, e_d;

  fp16_align dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .exponent_out(exponent_out), .mant_a_out(mant_a_out), .mant_b_out(mant_b_out),
    .sign_a_out(sign_a_out), .sign_b_out(sign_b_out), .swap_out(swap_out),
    .sticky_out(sticky_out), .special_out(special_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: align by plain arithmetic on the field values.
  task automatic model(input logic [15:0] a, input logic [15:0] b);
    int ra, rb, ea, eb, ma, mb, sa, sb, diff;
    ra = int'(a[14:10]); rb = int'(b[14:10]);
    ea = (ra == 0) ? 1 : ra;
    eb = (rb == 0) ? 1 : rb;
    ma = ((ra != 0) ? 1024 : 0) + int'(a[9:0]);
    mb = ((rb != 0) ? 1024 : 0) + int'(b[9:0]);
    sa = int'(a[15]); sb = int'(b[15]);
    e_sp = (ra == 31 || rb == 31) ? 1 : 0;
    e_sw = (eb > ea) ? 1 : 0;
    diff = (ea > eb) ? ea - eb : eb - ea;
    e_d  = e_sp ? 0 : ((diff > 12) ? 12 : diff);
    e_exp = e_sw ? eb : ea;
    e_ma  = e_sw ? mb : ma;
    e_sa  = e_sw ? sb : sa;
    e_sb  = e_sw ? sa : sb;
    e_mb  = (e_sw ? ma : mb) >> e_d;
    e_st  = (((e_sw ? ma : mb) % (1 << e_d)) != 0) ? 1 : 0;
  endtask

  task automatic check_result(input string tag);
    check({tag, ".valid"},   32'(out_valid), 1);
    check({tag, ".exp"},     32'(exponent_out), e_exp);
    check({tag, ".mant_a"},  32'(mant_a_out), e_ma);
    check({tag, ".mant_b"},  32'(mant_b_out), e_mb);
    check({tag, ".sign_a"},  32'(sign_a_out), e_sa);
    check({tag, ".sign_b"},  32'(sign_b_out), e_sb);
    check({tag, ".swap"},    32'(swap_out), e_sw);
    check({tag, ".sticky"},  32'(sticky_out), e_st);
    check({tag, ".special"}, 32'(special_out), e_sp);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 0);
    check({tag, ".data"},
          32'({exponent_out, mant_a_out, mant_b_out} == '0), 1);
    check({tag, ".flags"},
          32'({sign_a_out, sign_b_out, swap_out, sticky_out, special_out}), 0);
  endtask

  // Offers a pair (from #1 after an edge); it is captured at the next edge.
  task automatic present(input logic [15:0] a, input logic [15:0] b);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in = a; b_in = b;
    #1;
    check("in_ready", 32'(in_ready), 1);
    model(a, b);
  endtask

  // Full transaction: capture, timed wait for out_valid (junk offered while
  // busy must be ignored), optional stall in DONE, optional drain.
  task automatic txn(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int stall, input bit leave_done);
    present(a, b);
    @(posedge clk); #1;               // capture edge
    in_valid = 1'b0;
    for (int k = 0; k < e_d; k++) begin
      check({tag, ".early"}, 32'(out_valid), 0);
      check({tag, ".busy"},  32'(in_ready), 0);
      in_valid = 1'b1; a_in = 16'($urandom); b_in = 16'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_result(tag);
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        check_result({tag, ".hold"});
      end
    end
    if (!leave_done) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      check({tag, ".drain"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    #2;
    check_all_zero("reset");
    check("reset.in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    txn("one_half",  16'h3C00, 16'h3800, 0, 1'b0);
    txn("swapped",   16'h3800, 16'h3C00, 0, 1'b0);
    txn("swap_sign", 16'hB800, 16'h3C00, 0, 1'b0);
    txn("sat12",     16'h3C00, 16'h0001, 0, 1'b0);
    txn("inf",       16'h7C00, 16'h3C00, 0, 1'b0);
    txn("nan_b",     16'h3C00, 16'hFE01, 0, 1'b0);
    txn("equal",     16'h4500, 16'hC4FF, 0, 1'b0);
    txn("denorms",   16'h0003, 16'h03FF, 0, 1'b0);
    txn("sticky3",   16'h4C00, 16'h3807, 0, 1'b0);

    // stall 5 cycles in DONE, then back-to-back capture at the release edge
    txn("stall",     16'h4000, 16'h3A01, 5, 1'b1);
    txn("b2b",       16'h3555, 16'h4AAA, 0, 1'b1);
    txn("b2b2",      16'h7BFF, 16'h0400, 0, 1'b0);

    // reset in the middle of a long shift
    present(16'h3C00, 16'h0001);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_mid.in_ready", 32'(in_ready), 1);
    check_all_zero("rst_mid.after");
    txn("post_rst",  16'h3E00, 16'h3400, 0, 1'b0);

    // random pairs, biased toward close exponents so shifts vary
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 0) rb[14:10] = ra[14:10] - 5'($urandom_range(0, 4));
      txn("rand", ra, rb, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
